// File: rtl/mem_bus_master_pkg.sv
// Shared definitions for the memory bus master: state encoding, cpustate codes, region bounds.
package mem_bus_master_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } state_e;

    localparam logic [1:0] CPUSTATE_IN    = 2'b01;
    localparam logic [1:0] CPUSTATE_CHECK = 2'b10;
    localparam logic [1:0] CPUSTATE_RUN   = 2'b11;

    // Addresses with all bits from this one upward clear form the protected program region.
    localparam int unsigned PROG_REGION_MSB = 5;

    localparam int unsigned WAIT_W = 4;

endpackage

// File: rtl/mem_bus_waitctr.sv
// Loadable down-counter; done is high once the count has reached zero.
module mem_bus_waitctr #(
    parameter int unsigned Width = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             done_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/mem_bus_master.sv
// CPU-side memory bus initiator: 1/2-byte requests become strobed bus cycles with a wait window.
// Optional MEM_BUS_ERR_EN: reject program-region writes and report aborts through rsp_err.
module mem_bus_master
    import mem_bus_master_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          cpustate,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic                req_len,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic                rsp_valid,
    output logic [2*DATA_W-1:0] rsp_rdata,
    output logic                rsp_err,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic                bus_read,
    output logic                bus_write,
    output logic [DATA_W-1:0]   bus_dout,
    input  logic [DATA_W-1:0]   bus_din
);

    state_e              state_q, state_d;
    logic                we_q, we_d, len_q, len_d, idx_q, idx_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2*DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [DATA_W-1:0]   lo_q, lo_d;
    logic                run, accept, in_access;
    logic                ctr_load, ctr_dec, ctr_done;

`ifdef MEM_BUS_ERR_EN
    logic err_q, err_d, reject;

    function automatic logic in_prog(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1:PROG_REGION_MSB] == '0;
    endfunction

    assign reject = req_we &&
        (in_prog(req_addr) || (req_len && in_prog(req_addr + ADDR_W'(1))));
`endif

    mem_bus_waitctr #(
        .Width(WAIT_W)
    ) u_waitctr (
        .clk       (clk),
        .reset     (reset),
        .load_i    (ctr_load),
        .load_val_i(WAIT_W'(WAIT_CYCLES)),
        .dec_i     (ctr_dec),
        .done_o    (ctr_done)
    );

    assign run       = (cpustate == CPUSTATE_RUN);
    assign in_access = (state_q == StAccess);
    // Gate with reset so req_ready stays low for the whole reset assertion.
    assign req_ready = reset && (state_q == StIdle) && run;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        len_d    = len_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        lo_d     = lo_q;
        ctr_load = 1'b0;
        ctr_dec  = 1'b0;
`ifdef MEM_BUS_ERR_EN
        err_d    = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    we_d     = req_we;
                    len_d    = req_len;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    idx_d    = 1'b0;
                    ctr_load = 1'b1;
`ifdef MEM_BUS_ERR_EN
                    err_d    = reject;
                    state_d  = reject ? StResp : StAccess;
`else
                    state_d  = StAccess;
`endif
                end
            end
            StAccess: begin
                if (!run) begin
`ifdef MEM_BUS_ERR_EN
                    err_d   = 1'b1;
                    state_d = StResp;
`else
                    state_d = StIdle;
`endif
                end else if (!ctr_done) begin
                    ctr_dec = 1'b1;
                end else begin
                    // Stage byte 0 of a 2-byte read so rsp_rdata only changes on completion.
                    if (!we_q) begin
                        if (idx_q) begin
                            rdata_d = {bus_din, lo_q};
                        end else if (len_q) begin
                            lo_d = bus_din;
                        end else begin
                            rdata_d = {{DATA_W{1'b0}}, bus_din};
                        end
                    end
                    if (len_q && !idx_q) begin
                        idx_d    = 1'b1;
                        ctr_load = 1'b1;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            len_q   <= 1'b0;
            idx_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            lo_q    <= '0;
`ifdef MEM_BUS_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            lo_q    <= lo_d;
`ifdef MEM_BUS_ERR_EN
            err_q   <= err_d;
`endif
        end
    end

    assign bus_read  = in_access && !we_q;
    assign bus_write = in_access && we_q;
    assign bus_addr  = in_access ? (addr_q + ADDR_W'(idx_q)) : '0;
    assign bus_dout  = !in_access ? '0 :
                       idx_q ? wdata_q[2*DATA_W-1:DATA_W] : wdata_q[DATA_W-1:0];
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rdata_q;
`ifdef MEM_BUS_ERR_EN
    assign rsp_err   = (state_q == StResp) && err_q;
`else
    assign rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: directed scenarios plus randomized traffic
// checked cycle by cycle against a byte-array reference memory.
module tb_mem_bus_master;

    localparam int WAIT = 1;
    localparam int PER  = WAIT + 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  cpustate;
    logic        req_valid, req_ready, req_we, req_len;
    logic [15:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [15:0] rsp_rdata;
    logic [15:0] bus_addr;
    logic        bus_read, bus_write;
    logic [7:0]  bus_dout, bus_din;

    logic [7:0]  mem     [0:65535];
    logic [7:0]  ref_mem [0:65535];
    logic [15:0] last_rdata;
    int          n_tests = 0;
    int          n_fail  = 0;

    mem_bus_master #(
        .WAIT_CYCLES(WAIT),
        .ADDR_W     (16),
        .DATA_W     (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .cpustate (cpustate),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_len  (req_len),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err),
        .bus_addr (bus_addr),
        .bus_read (bus_read),
        .bus_write(bus_write),
        .bus_dout (bus_dout),
        .bus_din  (bus_din)
    );

    always #5 clk = ~clk;

    // Behavioural memory slave on the bus side.
    assign bus_din = mem[bus_addr];
    always @(posedge clk) if (bus_write) mem[bus_addr] <= bus_dout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_prog(input int a);
        return (a % 65536) < 32;
    endfunction

    // One full transaction, checked every cycle from acceptance to response.
    task automatic run_req(input bit we, input bit len, input int addr, input logic [15:0] wdata);
        bit  rej;
        int  lat, b, ea;
        logic [15:0] exp_rd;
        rej = 1'b0;
`ifdef MEM_BUS_ERR_EN
        rej = we && (in_prog(addr) || (len && in_prog(addr + 1)));
`endif
        lat = rej ? 1 : (int'(len) + 1) * PER + 1;
        cpustate  = 2'b11;
        req_valid = 1'b1;
        req_we    = we;
        req_len   = len;
        req_addr  = 16'(addr);
        req_wdata = wdata;
        @(negedge clk);
        check("req_ready_idle", req_ready, 1'b1);
        next_cycle();
        req_valid = 1'b0;
        exp_rd = len ? {ref_mem[(addr + 1) % 65536], ref_mem[addr % 65536]}
                     : {8'h00, ref_mem[addr % 65536]};
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k < lat) begin
                b  = (k - 1) / PER;
                ea = (addr + b) % 65536;
                check("bus_read", bus_read, !we);
                check("bus_write", bus_write, we);
                check("bus_addr", bus_addr, ea);
                if (we) check("bus_dout", bus_dout, b ? wdata[15:8] : wdata[7:0]);
                check("rsp_valid_busy", rsp_valid, 1'b0);
                check("req_ready_busy", req_ready, 1'b0);
            end else begin
                check("rsp_valid", rsp_valid, 1'b1);
                check("rsp_err", rsp_err, rej);
                check("strobes_resp", {bus_read, bus_write}, 2'b00);
                if (!we) last_rdata = exp_rd;
                check("rsp_rdata", rsp_rdata, last_rdata);
            end
            next_cycle();
        end
        if (we && !rej) begin
            ref_mem[addr % 65536] = wdata[7:0];
            if (len) ref_mem[(addr + 1) % 65536] = wdata[15:8];
        end
        @(negedge clk);
        check("rsp_valid_after", rsp_valid, 1'b0);
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[16'h0020]     = 8'hA5;
        ref_mem[16'h0020] = 8'hA5;
        last_rdata = 16'h0000;
        reset     = 1'b0;
        cpustate  = 2'b11;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_len   = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 16'h0000;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_strobes", {bus_read, bus_write}, 2'b00);
        check("rst_bus_addr", bus_addr, 16'h0000);
        check("rst_bus_dout", bus_dout, 8'h00);
        check("rst_rsp_rdata", rsp_rdata, 16'h0000);
        next_cycle();
        reset = 1'b1;

        // Request held while not in RUN is ignored, then accepted once RUN is entered.
        cpustate  = 2'b01;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 16'h0100;
        req_wdata = 16'h0077;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("hold_req_ready", req_ready, 1'b0);
            check("hold_bus_idle", {bus_read, bus_write}, 2'b00);
            next_cycle();
        end
        run_req(1'b1, 1'b0, 16'h0100, 16'h0077);

        // Directed accesses
        run_req(1'b0, 1'b0, 16'h0020, 16'h0000);
        run_req(1'b1, 1'b1, 16'hFFFF, 16'h3C5A);
        run_req(1'b0, 1'b1, 16'hFFFF, 16'h0000);
        run_req(1'b1, 1'b0, 16'h001F, 16'h00EE);
        run_req(1'b1, 1'b0, 16'h0020, 16'h0000);
        run_req(1'b0, 1'b1, 16'h001F, 16'h0000);

        // cpustate leaves RUN during the first ACCESS cycle of a read.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_len   = 1'b0;
        req_addr  = 16'h0020;
        next_cycle();
        req_valid = 1'b0;
        cpustate  = 2'b10;
        @(negedge clk);
        check("abort_read_t1", bus_read, 1'b1);
        next_cycle();
        @(negedge clk);
        check("abort_read_t2", bus_read, 1'b0);
`ifdef MEM_BUS_ERR_EN
        check("abort_rsp_valid", rsp_valid, 1'b1);
        check("abort_rsp_err", rsp_err, 1'b1);
`else
        check("abort_rsp_valid", rsp_valid, 1'b0);
        check("abort_rsp_err", rsp_err, 1'b0);
`endif
        check("abort_rdata_kept", rsp_rdata, last_rdata);
        next_cycle();
        @(negedge clk);
        check("abort_rsp_valid_t3", rsp_valid, 1'b0);
        check("abort_bus_idle_t3", {bus_read, bus_write}, 2'b00);
        next_cycle();
        cpustate = 2'b11;

        // Reset asserted during ACCESS of a 1-byte read.
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 16'h0040;
        next_cycle();
        req_valid = 1'b0;
        reset     = 1'b0;
        @(negedge clk);
        check("rstmid_bus_read", bus_read, 1'b0);
        check("rstmid_req_ready", req_ready, 1'b0);
        check("rstmid_rdata", rsp_rdata, 16'h0000);
        next_cycle();
        @(negedge clk);
        check("rstmid_rsp_valid", rsp_valid, 1'b0);
        check("rstmid_req_ready2", req_ready, 1'b0);
        next_cycle();
        reset = 1'b1;
        last_rdata = 16'h0000;
        @(negedge clk);
        check("rstmid_ready_after", req_ready, 1'b1);
        check("rstmid_no_rsp", rsp_valid, 1'b0);
        next_cycle();

        // Randomized traffic over a few small windows so reads revisit written bytes.
        for (int i = 0; i < 80; i++) begin
            int  sel, a;
            sel = int'($urandom_range(0, 2));
            if (sel == 0)      a = 16'h0018 + int'($urandom_range(0, 15));
            else if (sel == 1) a = (16'hFFF8 + int'($urandom_range(0, 15))) % 65536;
            else               a = 16'h0100 + int'($urandom_range(0, 31));
            run_req(1'($urandom), 1'($urandom), a, 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
- CPU-side initiator for the 8-bit/16-bit-address memory bus served by the instruction/data memory.
- Accepts byte or 2-byte access requests from the control unit via a valid/ready handshake.
- Drives addr/read/write/data onto the bus, holds strobes for a programmable wait window, samples read data and returns a single-cycle response.
- Active only while cpustate indicates RUN (2'b11).

Parameters:
- WAIT_CYCLES, 1, extra cycles strobes are held beyond the first access cycle (0..15).
- ADDR_W, 16, bus address width.
- DATA_W, 8, bus data width.

Ports:
- clk  input  1  system clock (divided clock), rising edge.
- reset  input  1  asynchronous, active-low reset.
- cpustate  input  2  01=IN, 10=CHECK, 11=RUN.
- req_valid  input  1  control unit request present.
- req_ready  output  1  master can accept a request this cycle.
- req_we  input  1  1=write, 0=read.
- req_len  input  1  0=1 byte, 1=2 bytes (addr, addr+1).
- req_addr  input  ADDR_W  start address.
- req_wdata  input  2*DATA_W  write data; byte0=[7:0], byte1=[15:8].
- rsp_valid  output  1  one-cycle pulse, access complete.
- rsp_rdata  output  2*DATA_W  read data, byte0 in [7:0]; [15:8]=0 for 1-byte reads.
- rsp_err  output  1  error flag qualified by rsp_valid (0 unless MEM_BUS_ERR_EN).
- bus_addr  output  ADDR_W  to memory addr.
- bus_read  output  1  to memory read.
- bus_write  output  1  to memory write.
- bus_dout  output  DATA_W  to memory data_in.
- bus_din  input  DATA_W  from memory data_out (high-Z outside RUN).

Behaviour:
- Reset (async, reset=0): state=IDLE. All outputs 0: req_ready, rsp_valid, rsp_err, bus_read, bus_write. bus_addr=0, bus_dout=0, rsp_rdata=0.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = (cpustate==2'b11).
  - On req_valid&&req_ready at edge T: latch we, len, addr, wdata; byte index=0; wait counter=WAIT_CYCLES; go to ACCESS.
- ACCESS:
  - bus_addr = latched addr + byte index, wrapping modulo 2^ADDR_W (16'hFFFF+1 -> 16'h0000).
  - bus_read = !we; bus_write = we; bus_dout = selected wdata byte. All held constant for WAIT_CYCLES+1 cycles.
  - On the final cycle's edge, reads capture bus_din into the rsp_rdata byte slot.
  - If len=1 and byte 0 is done: byte index=1, counter reloads, stay in ACCESS. There is no idle gap between bytes.
  - Otherwise go to RESP.
- RESP: rsp_valid=1 for exactly one cycle; strobes=0; req_ready=0; then IDLE. There is no response backpressure.
- Latency with WAIT_CYCLES=1:
  - 1-byte access: rsp_valid in cycle T+3.
  - 2-byte access: rsp_valid in cycle T+5.
  - General: accept-to-rsp = (len+1)*(WAIT_CYCLES+1)+1 cycles.
- req_ready=0 in ACCESS and RESP. Requests presented then are ignored and must be held by the requester.
- cpustate leaves 2'b11 during ACCESS:
  - Strobes drop the next cycle and the transfer is aborted.
  - Goes to RESP with rsp_err=1 if MEM_BUS_ERR_EN, else returns to IDLE with no rsp_valid.
  - Partial write bytes already strobed remain in memory.
- rsp_rdata holds its value until the next read completes. Writes leave rsp_rdata unchanged.
- A write data byte of 8'h00 is still strobed; memory-side policy on zero data is not this block's concern.
- bus_din is sampled only in ACCESS with cpustate==2'b11.

Optional Feature:
- Macro: MEM_BUS_ERR_EN.
- Defined:
  - A write request whose target byte has addr[15:5]==0 (program region, 0..31) is rejected with no bus cycle: IDLE -> RESP, rsp_valid=1, rsp_err=1, latency 1 cycle.
  - For 2-byte writes, either byte in the region rejects the whole request.
  - An abort due to a cpustate change also reports rsp_err=1.
- Undefined: rsp_err is tied 0; all writes are issued; aborts are silent.

Decomposition:
- Shared include mem_bus_defs: state encodings (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2), CPUSTATE_IN/CHECK/RUN constants, PROG_REGION_MSB=5.
- One sub-module: mem_bus_waitctr, a loadable down-counter with a done flag, reused per byte.

Test Plan:
- Reset mid-ACCESS (1-byte read, drive reset=0 at T+1) -> bus_read=0 immediately, req_ready=0 until reset=1 with cpustate=11, no rsp_valid.
- cpustate=11, WAIT_CYCLES=1, 1-byte read addr=16'h0020, bus_din=8'hA5 -> bus_read high cycles T+1..T+2, rsp_valid at T+3, rsp_rdata=16'h00A5.
- 2-byte write addr=16'hFFFF, wdata=16'h3C5A -> bus_addr=FFFF with dout=5A, then 0000 with dout=3C, each with 2 write cycles, rsp_valid at T+5.
- 1-byte read with cpustate switched to 10 at T+1 -> strobe drops at T+2; rsp_valid absent, or rsp_valid+rsp_err=1 if MEM_BUS_ERR_EN.
- With MEM_BUS_ERR_EN, write addr=16'h001F -> no bus_write ever, rsp_valid at T+1, rsp_err=1; same test at addr=16'h0020 -> normal write, rsp_err=0.
- req_valid held with cpustate=01 -> req_ready=0, no bus activity for 20 cycles; switch to 11 -> accepted the same cycle.
